sequence_serializer: RTL and testbench

Parallel-to-serial front end for the `sequence_detector` stage. It accepts `WIDTH`-bit words over a valid/ready handshake and buffers them in a `DEPTH`-entry FIFO. It then shifts each word out one bit per clock on `data_out`, which connects directly to the detector's `data_in`. Words are emitted back-to-back with no idle gap while the FIFO holds data.

---
 rtl/sequence_serializer_if.sv | 25 ++
 rtl/sequence_serializer.sv | 117 +++++++++++
 tb/tb_sequence_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sequence_serializer_if.sv
// Word-in / bit-out bundle between a word producer, the serializer and the
// downstream detector tap; the master modport is the producer side.
interface sequence_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         word_in;
    logic                     word_valid;
    logic                     word_ready;
    logic                     flush;
    logic                     data_out;
    logic                     bit_valid;
    logic                     frame_start;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output word_in, word_valid, flush,
        input  word_ready, data_out, bit_valid, frame_start, level
    );

    modport slave (
        input  word_in, word_valid, flush,
        output word_ready, data_out, bit_valid, frame_start, level
    );
endinterface

// File: rtl/sequence_serializer.sv
// Parallel-to-serial front end: buffers words in a DEPTH-entry FIFO and shifts them out one bit per clock.
// Latency: first bit registered one edge after the accepting edge; words follow back-to-back with no gap.
// Backpressure: word_ready drops while the FIFO is full (a same-cycle pop does not reopen it) or during flush.
module sequence_serializer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    sequence_serializer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, head;
    logic             data_q, data_d, vld_q, vld_d, fs_q, fs_d;
    logic             push, pop;

    assign bus.word_ready  = reset && !bus.flush && (level_q < LW'(DEPTH));
    assign push            = bus.word_valid && bus.word_ready;
    // Pop uses the pre-edge level, so a word pushed into an empty FIFO waits one edge.
    assign pop             = !bus.flush && (level_q != '0) && ((state_q == IDLE) || (cnt_q == '0));
    assign head            = mem_q[rd_ptr_q];

    assign bus.data_out    = data_q;
    assign bus.bit_valid   = vld_q;
    assign bus.frame_start = fs_q;
    assign bus.level       = level_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.word_in;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        vld_d    = vld_q;
        fs_d     = fs_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = IDLE;
            data_d   = IDLE_BIT;
            vld_d    = 1'b0;
            fs_d     = 1'b0;
        end else if (pop) begin
            state_d = SHIFT;
            cnt_d   = CW'(WIDTH - 1);
            vld_d   = 1'b1;
            fs_d    = 1'b1;
            if (MSB_FIRST) begin
                data_d  = head[WIDTH-1];
                shreg_d = {head[WIDTH-2:0], 1'b0};
            end else begin
                data_d  = head[0];
                shreg_d = {1'b0, head[WIDTH-1:1]};
            end
        end else if (state_q == SHIFT && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            fs_d  = 1'b0;
            if (MSB_FIRST) begin
                data_d  = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                data_d  = shreg_q[0];
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
            data_d  = IDLE_BIT;
            vld_d   = 1'b0;
            fs_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            data_q   <= IDLE_BIT;
            vld_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            fs_q     <= fs_d;
        end
    end
endmodule

// File: tb/tb_sequence_serializer.sv
// Bench for sequence_serializer: queue-based reference model for the MSB-first instance,
// plus directed literal checks on both an MSB-first and an LSB-first instance.
module tb_sequence_serializer;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    sequence_serializer_if #(.WIDTH(8), .DEPTH(4)) sif ();
    sequence_serializer_if #(.WIDTH(8), .DEPTH(4)) lif ();

    sequence_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clock (clock),
        .reset (rst_n),
        .bus   (sif)
    );
    sequence_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clock (clock),
        .reset (rst_n),
        .bus   (lif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of words, shifter as a queue of bits still to present.
    logic [7:0] mq[$];
    bit         rem[$];
    logic       m_dat = 1'b0, m_vld = 1'b0, m_fs = 1'b0;
    logic [7:0] m_w;
    bit         m_push;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n || sif.flush) begin
            mq.delete();
            rem.delete();
            m_dat = 1'b0; m_vld = 1'b0; m_fs = 1'b0;
        end else begin
            m_push = sif.word_valid && (mq.size() < 4);
            if (m_vld && rem.size() > 0) begin
                m_dat = rem.pop_front();
                m_fs  = 1'b0;
            end else if (mq.size() > 0) begin
                m_w = mq.pop_front();
                rem.delete();
                for (int i = 7; i >= 0; i--) rem.push_back(m_w[i]);
                m_dat = rem.pop_front();
                m_fs  = 1'b1;
                m_vld = 1'b1;
            end else begin
                m_dat = 1'b0; m_vld = 1'b0; m_fs = 1'b0;
            end
            if (m_push) mq.push_back(sif.word_in);
        end
    end

    int max_level = 0;
    int fs_count  = 0;
    bit saw_full  = 0;

    always @(negedge clock) begin
        chk("data_out", sif.data_out, m_dat);
        chk("bit_valid", sif.bit_valid, m_vld);
        chk("frame_start", sif.frame_start, m_fs);
        chk("level", sif.level, mq.size());
        chk("word_ready", sif.word_ready, rst_n && !sif.flush && (mq.size() < 4));
        if (int'(sif.level) > max_level) max_level = int'(sif.level);
        if (sif.frame_start) fs_count++;
        if (rst_n && sif.level == 4 && !sif.word_ready) saw_full = 1;
    end

    task automatic push_word(input bit lsb, input logic [7:0] w);
        bit ok;
        int k;
        if (lsb) begin lif.word_in = w; lif.word_valid = 1'b1; end
        else     begin sif.word_in = w; sif.word_valid = 1'b1; end
        ok = 0;
        k  = 0;
        while (!ok && k < 50) begin
            @(negedge clock);
            ok = lsb ? lif.word_ready : sif.word_ready;
            @(posedge clock);
            #2;
            k++;
        end
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic expect_bits(input bit lsb, input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("lit_bit_valid", lsb ? lif.bit_valid : sif.bit_valid, 1);
            chk("lit_data_out", lsb ? lif.data_out : sif.data_out, pat[n-1-i]);
            chk("lit_frame_start", lsb ? lif.frame_start : sif.frame_start, (i % 8) == 0);
        end
        @(negedge clock);
        chk("lit_bit_valid_drop", lsb ? lif.bit_valid : sif.bit_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int fs_base;

    initial begin
        sif.word_in = '0; sif.word_valid = 1'b0; sif.flush = 1'b0;
        lif.word_in = '0; lif.word_valid = 1'b0; lif.flush = 1'b0;

        repeat (2) @(posedge clock);
        #2 rst_n = 1'b1;
        @(negedge clock);
        chk("rst_data_out", sif.data_out, 0);
        chk("rst_bit_valid", sif.bit_valid, 0);
        chk("rst_level", sif.level, 0);
        chk("rst_word_ready", sif.word_ready, 1);

        // Single word, MSB first.
        @(posedge clock); #2;
        push_word(0, 8'hB3);
        sif.word_valid = 1'b0;
        @(posedge clock);
        expect_bits(0, 16'h00B3, 8);

        // Back-to-back words form one contiguous 16-bit run.
        @(posedge clock); #2;
        push_word(0, 8'hA5);
        push_word(0, 8'h0F);
        sif.word_valid = 1'b0;
        expect_bits(0, 16'hA50F, 16);

        // Six pushes from idle fill the FIFO; all six must come out.
        repeat (3) @(posedge clock); #2;
        fs_base   = fs_count;
        max_level = 0;
        saw_full  = 0;
        for (int i = 0; i < 6; i++) push_word(0, 8'(8'h31 * (i + 1)));
        sif.word_valid = 1'b0;
        repeat (60) @(posedge clock);
        chk("full_max_level", max_level, 4);
        chk("full_saw_not_ready", saw_full, 1);
        chk("full_word_count", fs_count - fs_base, 6);

        // Flush at bit 3 of 8'hFF with two words queued.
        #2;
        push_word(0, 8'hFF);
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        sif.word_valid = 1'b0;
        @(posedge clock); #2;
        chk("pre_flush_level", sif.level, 2);
        chk("pre_flush_data_out", sif.data_out, 1);
        sif.flush = 1'b1;
        @(posedge clock); #2;
        sif.flush = 1'b0;
        @(negedge clock);
        chk("flush_bit_valid", sif.bit_valid, 0);
        chk("flush_data_out", sif.data_out, 0);
        chk("flush_level", sif.level, 0);
        @(posedge clock); #2;
        push_word(0, 8'h80);
        sif.word_valid = 1'b0;
        @(posedge clock);
        expect_bits(0, 16'h0080, 8);

        // LSB-first instance: 8'h01 goes out as 1 then seven 0s.
        @(posedge clock); #2;
        push_word(1, 8'h01);
        lif.word_valid = 1'b0;
        @(posedge clock);
        expect_bits(1, 16'h0080, 8);

        // Asynchronous reset in the middle of a word, between clock edges.
        @(posedge clock); #2;
        push_word(1, 8'h01);
        lif.word_valid = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        chk("pre_arst_bit_valid", lif.bit_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_bit_valid", lif.bit_valid, 0);
        chk("arst_data_out", lif.data_out, 0);
        chk("arst_frame_start", lif.frame_start, 0);
        chk("arst_word_ready", lif.word_ready, 0);
        chk("arst_level", lif.level, 0);
        repeat (2) @(posedge clock);
        #2 rst_n = 1'b1;
        @(negedge clock);
        chk("rel_word_ready", lif.word_ready, 1);
        chk("rel_bit_valid", lif.bit_valid, 0);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
